// File: rtl/lru_victim_select_if.sv
// Access/lookup bus for the per-set true-LRU tracker.
// The cache controller drives updates and lookups; the tracker returns the victim way.
interface lru_victim_select_if #(
   parameter int N      = 2,
   parameter int S_BITS = 3
);
   logic              upd_valid;
   logic [S_BITS-1:0] upd_set;
   logic [N-1:0]      upd_way;
   logic              req_valid;
   logic [S_BITS-1:0] req_set;
   logic              victim_valid;
   logic [N-1:0]      victim_idx;

   modport master (
      output upd_valid, upd_set, upd_way, req_valid, req_set,
      input  victim_valid, victim_idx
   );

   modport slave (
      input  upd_valid, upd_set, upd_way, req_valid, req_set,
      output victim_valid, victim_idx
   );
endinterface

// File: rtl/lru_victim_select.sv
// True-LRU age tracker: one age-rank permutation per set, registered victim lookup.
// Age 0 is MRU, age W-1 is LRU; a lookup returns the way holding age W-1.

module lru_victim_select_set #(
   parameter int N = 2,
   parameter int W = 1 << N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_upd,
   input  logic [N-1:0] i_way,
   output logic [N-1:0] o_lru_way
);
   logic [W-1:0][N-1:0] r_age;
   logic [N-1:0]        w_a;

   assign w_a = r_age[i_way];

   // Only ways younger than the accessed one age by one, so the set stays a permutation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < W; w++) r_age[w] <= N'(W - 1 - w);
      end else if (i_upd) begin
         for (int w = 0; w < W; w++) begin
            if (N'(w) == i_way)    r_age[w] <= '0;
            else if (r_age[w] < w_a) r_age[w] <= r_age[w] + N'(1);
         end
      end
   end

   always_comb begin
      o_lru_way = '0;
      for (int w = 0; w < W; w++)
         if (r_age[w] == N'(W - 1)) o_lru_way = N'(w);
   end
endmodule

module lru_victim_select #(
   parameter int N      = 2,
   parameter int W      = 1 << N,
   parameter int S_BITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   lru_victim_select_if.slave  bus
);
   localparam int SETS = 1 << S_BITS;

   logic [N-1:0] w_lru [SETS];
   logic         r_victim_valid;
   logic [N-1:0] r_victim_idx;

   for (genvar g = 0; g < SETS; g++) begin : g_set
      logic w_upd;
      assign w_upd = bus.upd_valid && (bus.upd_set == S_BITS'(g));
      lru_victim_select_set #(.N(N), .W(W)) u_set (
         .clk      (clk),
         .rst      (rst),
         .i_upd    (w_upd),
         .i_way    (bus.upd_way),
         .o_lru_way(w_lru[g])
      );
   end

   // Lookup reads the ages before this edge's update commits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_victim_valid <= 1'b0;
         r_victim_idx   <= '0;
      end else begin
         r_victim_valid <= bus.req_valid;
         if (bus.req_valid) r_victim_idx <= w_lru[bus.req_set];
      end
   end

   assign bus.victim_valid = r_victim_valid;
   assign bus.victim_idx   = r_victim_idx;
endmodule

// File: tb/tb_lru_victim_select.sv
// Bench for lru_victim_select: directed vector table, reset corner case, and
// randomized traffic against an age-array reference model.
module tb_lru_victim_select;
   localparam int N = 2;
   localparam int W = 4;
   localparam int S_BITS = 3;
   localparam int SETS = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lru_victim_select_if #(.N(N), .S_BITS(S_BITS)) bus ();

   lru_victim_select #(.N(N), .W(W), .S_BITS(S_BITS)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int uv, us, uw, rv, rs;
      int exp_vv, exp_idx;
   } vec_t;
   vec_t tbl[$];

   int mage [SETS][W];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input int uv, us, uw, rv, rs, evv, eidx);
      vec_t v;
      v.uv = uv; v.us = us; v.uw = uw; v.rv = rv; v.rs = rs;
      v.exp_vv = evv; v.exp_idx = eidx;
      tbl.push_back(v);
   endfunction

   function automatic void mreset();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < W; w++) mage[s][w] = W - 1 - w;
   endfunction

   function automatic void mupd(input int s, input int w);
      int a = mage[s][w];
      for (int v = 0; v < W; v++)
         if (v == w) mage[s][v] = 0;
         else if (mage[s][v] < a) mage[s][v] = mage[s][v] + 1;
   endfunction

   function automatic int mlru(input int s);
      for (int v = 0; v < W; v++) if (mage[s][v] == W - 1) return v;
      return -1;
   endfunction

   task automatic drive(input int uv, us, uw, rv, rs);
      bus.upd_valid = uv[0];
      bus.upd_set   = S_BITS'(us);
      bus.upd_way   = N'(uw);
      bus.req_valid = rv[0];
      bus.req_set   = S_BITS'(rs);
   endtask

   initial begin
      int prev_idx;
      int evv, eidx, uv, us, uw, rv, rs;
      drive(0, 0, 0, 0, 0);

      // reset behaviour
      add(0,0,0, 1,3, 1,0);
      add(0,0,0, 0,0, 0,0);
      // fill stream on set 0: victim, then update that way
      add(0,0,0, 1,0, 1,0);  add(1,0,0, 0,0, 0,0);
      add(0,0,0, 1,0, 1,1);  add(1,0,1, 0,0, 0,1);
      add(0,0,0, 1,0, 1,2);  add(1,0,2, 0,0, 0,2);
      add(0,0,0, 1,0, 1,3);  add(1,0,3, 0,0, 0,3);
      add(0,0,0, 1,0, 1,0);
      // set 1: way 2 then way 0
      add(1,1,2, 0,0, 0,0);  add(0,0,0, 1,1, 1,0);
      add(1,1,0, 0,0, 0,0);  add(0,0,0, 1,1, 1,1);
      // set 2: repeated MRU hits change nothing
      add(1,2,3, 0,0, 0,1);  add(1,2,3, 0,0, 0,1);
      add(0,0,0, 1,2, 1,0);
      // set 4: same-cycle update and lookup sees pre-update ages
      add(1,4,0, 1,4, 1,0);  add(0,0,0, 1,4, 1,1);
      // untouched and earlier sets still intact
      add(0,0,0, 1,1, 1,1);  add(0,0,0, 1,7, 1,0);
      // different-set update and lookup in one cycle
      add(1,6,0, 1,0, 1,0);  add(0,0,0, 1,6, 1,1);

      #1;
      chk("reset_vv", int'(bus.victim_valid), 0);
      chk("reset_idx", int'(bus.victim_idx), 0);
      @(negedge clk); rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].uv, tbl[i].us, tbl[i].uw, tbl[i].rv, tbl[i].rs);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_vv", i), int'(bus.victim_valid), tbl[i].exp_vv);
         chk($sformatf("vec%0d_idx", i), int'(bus.victim_idx), tbl[i].exp_idx);
      end

      // set 5 updates, then async reset while a result is valid
      @(negedge clk); drive(1,5,0, 0,0);
      @(negedge clk); drive(1,5,1, 0,0);
      @(negedge clk); drive(0,0,0, 1,5);
      @(posedge clk); #1;
      chk("set5_pre_vv", int'(bus.victim_valid), 1);
      chk("set5_pre_idx", int'(bus.victim_idx), 2);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_vv", int'(bus.victim_valid), 0);
      chk("async_rst_idx", int'(bus.victim_idx), 0);
      drive(1,5,3, 1,5);
      @(posedge clk); #1;
      chk("rst_ignores_in_vv", int'(bus.victim_valid), 0);
      @(negedge clk); rst = 1'b0; drive(0,0,0, 1,5);
      @(posedge clk); #1;
      chk("set5_post_idx", int'(bus.victim_idx), 0);
      chk("set5_post_vv", int'(bus.victim_valid), 1);
      @(negedge clk); drive(0,0,0, 1,1);
      @(posedge clk); #1;
      chk("set1_post_rst", int'(bus.victim_idx), 0);

      // randomized traffic against the reference model
      mreset();
      prev_idx = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         uv = int'($urandom_range(0, 1));
         us = int'($urandom_range(0, SETS - 1));
         uw = int'($urandom_range(0, W - 1));
         rv = int'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) == 0) ? us : int'($urandom_range(0, SETS - 1));
         drive(uv, us, uw, rv, rs);
         evv = rv;
         eidx = rv ? mlru(rs) : prev_idx;
         prev_idx = eidx;
         if (uv != 0) mupd(us, uw);
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_vv", c), int'(bus.victim_valid), evv);
         chk($sformatf("rnd%0d_idx", c), int'(bus.victim_idx), eidx);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
